// File: rtl/rv_div_pkg.sv
// Shared constants, op codes and state encodings for the RV32M divide sequencer.
package rv_div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_ITERS = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [2:0] {
        DIV_ST_IDLE = 3'd0,
        DIV_ST_PREP = 3'd1,
        DIV_ST_ITER = 3'd2,
        DIV_ST_FIX  = 3'd3,
        DIV_ST_DONE = 3'd4
    } div_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

    // funct3[0] clear selects the signed flavours (DIV, REM).
    function automatic logic div_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem, quo}.
module div_step
    import rv_div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;

    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};

    // A set MSB on the XLEN+1 bit trial means the divisor did not fit: restore.
    assign o_rem = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring divide with RISC-V special cases.
// Build option DIV_EARLY_OUT_EN skips the iterations when |divisor| > |dividend|.
module div_ctrl
    import rv_div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int ITERS = DIV_ITERS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opr_1,
    input  logic [XLEN-1:0] opr_2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out,
    output logic [2:0]      dbg_state
);

    localparam int CNT_W = $clog2(ITERS);

    // Handshake: start is taken only while busy is low; done pulses for one
    // cycle with out valid, and out then holds until the next done.

    div_state_e      r_state;
    div_state_e      w_state_nxt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_out;
    logic [CNT_W-1:0] r_cnt;
    logic            r_q_neg;
    logic            r_r_neg;

    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_signed;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_div_abs;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;
    logic [XLEN-1:0] w_fix_res;
`ifdef DIV_EARLY_OUT_EN
    logic            w_early;
    assign w_early = (w_div_abs > w_dvd_abs);
`endif

    assign w_div_zero = (opr_2 == '0);
    assign w_ovf      = div_is_signed(op) && (opr_1 == DIV_OVF_Q) && (opr_2 == '1);
    assign w_fast     = w_div_zero || w_ovf;
    assign w_fast_res = w_div_zero ? (op[1] ? opr_1 : DIV_BY_ZERO_Q)
                                   : (op[1] ? '0 : DIV_OVF_Q);

    // In PREP r_quo/r_div still hold the raw operands captured at start.
    assign w_signed  = div_is_signed(r_op);
    assign w_dvd_abs = (w_signed && r_quo[XLEN-1]) ? -r_quo : r_quo;
    assign w_div_abs = (w_signed && r_div[XLEN-1]) ? -r_div : r_div;

    assign w_fix_res = r_op[1] ? (r_r_neg ? -r_rem : r_rem)
                               : (r_q_neg ? -r_quo : r_quo);

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_fast ? DIV_ST_DONE : DIV_ST_PREP;
                end
            end
            DIV_ST_PREP: begin
`ifdef DIV_EARLY_OUT_EN
                w_state_nxt = w_early ? DIV_ST_FIX : DIV_ST_ITER;
`else
                w_state_nxt = DIV_ST_ITER;
`endif
            end
            DIV_ST_ITER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DIV_ST_FIX;
                end
            end
            DIV_ST_FIX:  w_state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: w_state_nxt = DIV_ST_IDLE;
            default:     w_state_nxt = DIV_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else begin
            case (r_state)
                DIV_ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_quo <= opr_1;
                        r_div <= opr_2;
                        if (w_fast) begin
                            r_out <= w_fast_res;
                        end
                    end
                end
                DIV_ST_PREP: begin
                    r_quo   <= w_dvd_abs;
                    r_div   <= w_div_abs;
                    r_rem   <= '0;
                    r_cnt   <= CNT_W'(ITERS - 1);
                    r_q_neg <= w_signed && (r_quo[XLEN-1] ^ r_div[XLEN-1]);
                    r_r_neg <= w_signed && r_quo[XLEN-1];
`ifdef DIV_EARLY_OUT_EN
                    if (w_early) begin
                        r_quo <= '0;
                        r_rem <= w_dvd_abs;
                    end
`endif
                end
                DIV_ST_ITER: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt - 1'b1;
                end
                DIV_ST_FIX: begin
                    r_out <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != DIV_ST_IDLE);
    assign done      = (r_state == DIV_ST_DONE);
    assign out       = r_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: arithmetic/latency model checked every cycle plus literal vectors.
module tb_div_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opr_1;
    logic [31:0] opr_2;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_EO = 3;
`else
    localparam int LAT_EO = 35;
`endif

    div_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .opr_1     (opr_1),
        .opr_2     (opr_2),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (!o[0]) begin
            sa = a;
            sb = b;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        logic [31:0] aa;
        logic [31:0] ab;
        if (b == 32'h0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        aa = (!o[0] && a[31]) ? -a : a;
        ab = (!o[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (ab > aa) return 3;
`else
        if (ab > aa) return 35;
`endif
        return 35;
    endfunction

    logic [31:0] exp_q[$];
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_lat    = 0;
    logic [31:0] m_held   = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_k      = 0;
            m_held   = 32'h0;
            exp_q.delete();
        end else if (m_active) begin
            if (m_k == m_lat) m_active = 1'b0;
            else m_k = m_k + 1;
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 1;
            m_lat    = model_lat(op, opr_1, opr_2);
            exp_q.push_back(model_res(op, opr_1, opr_2));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit          e_done;
        logic [31:0] e_out;
        e_done = m_active && (m_k == m_lat);
        e_out  = m_held;
        if (e_done && exp_q.size() > 0) begin
            e_out  = exp_q.pop_front();
            m_held = e_out;
        end
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(e_done));
        chk("out",  out, e_out);
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_val, input int exp_lat);
        int n;
        bit seen;
        start = 1'b1;
        op    = o;
        opr_1 = a;
        opr_2 = b;
        n     = cyc;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        opr_1 = $urandom;
        opr_2 = $urandom;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                chk({name, "_lat"}, 32'(cyc - n), 32'(exp_lat));
                chk({name, "_out"}, out, exp_val);
            end else begin
                @(negedge clk);
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        opr_1 = 32'h0;
        opr_2 = 32'h0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_out",   out, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'd0);

        run_op("div_20_m3",    2'b00, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 35);
        run_op("rem_20_m3",    2'b10, 32'd20,         32'hFFFF_FFFD, 32'h0000_0002, 35);
        run_op("rem_m20_3",    2'b10, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 35);
        run_op("divu_max_16",  2'b01, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 35);
        run_op("remu_max_16",  2'b11, 32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 35);
        run_op("divu_by0",     2'b01, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",      2'b10, 32'd1234,       32'd0,         32'h0000_04D2, 1);
        run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
        run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
        run_op("div_min_2",    2'b00, 32'h8000_0000,  32'd2,         32'hC000_0000, 35);
        run_op("divu_3_10",    2'b01, 32'd3,          32'd10,        32'h0000_0000, LAT_EO);
        run_op("remu_min_max", 2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_EO);

        // start pulses at N+5 and in the DONE cycle must both be dropped
        start = 1'b1; op = 2'b00; opr_1 = 32'd100; opr_2 = 32'd7;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 45; i++) begin
            if (done) begin
                dones++;
                chk("ign_lat", 32'(cyc - n), 32'd35);
                chk("ign_out", out, 32'd14);
            end
            start = ((cyc - n) == 5) || ((cyc - n) == 35);
            op    = 2'b01;
            opr_1 = 32'd1;
            opr_2 = 32'd0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("ign_done_count", 32'(dones), 32'd1);

        // reset in the middle of an operation
        start = 1'b1; op = 2'b00; opr_1 = 32'd100; opr_2 = 32'd7;
        n = cyc;
        @(negedge clk);
        start = 1'b0;
        while ((cyc - n) < 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out",  out, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        run_op("div_9_2", 2'b00, 32'd9, 32'd2, 32'd4, 35);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
